up_down_counter_param: RTL

Parametrised synchronous up/down counter that generalises the team's 4-bit T-flip-flop up/down counter.
- Adds configurable width, a runtime modulus, synchronous load, count enable and wrap/saturate mode.
- Adds registered wrap and saturate event pulses.
- Used as the general-purpose event/position counter in datapath and timer blocks; drop-in for the fixed 4-bit counter when WIDTH=4, max_val=15, sat_mode=0 and en=1.

---
 rtl/up_down_counter_param.sv | 98 +++++++++
 1 files changed

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with runtime modulus, load, enable and wrap/saturate mode.
// Define UDCNT_STICKY_OVF_EN to add the clr_ovf input and the ovf_sticky overflow flag.
module up_down_counter_param #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_evt,
    output logic             sat_hit
`ifdef UDCNT_STICKY_OVF_EN
    ,
    input  logic             clr_ovf,
    output logic             ovf_sticky
`endif
);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             at_top;
    logic             at_zero;
    logic             over_range;

    assign at_top     = (count >= max_val);
    assign at_zero    = (count == '0);
    assign over_range = (count > max_val);

    assign tc = en & ~load & ((up & at_top) | (~up & down & at_zero));

    // up wins over down; out-of-range counts snap back to a range end
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        sat_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up) begin
                if (!at_top) begin
                    count_nxt = count + WIDTH'(1);
                end else if (sat_mode) begin
                    count_nxt = max_val;
                    sat_nxt   = 1'b1;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else if (down) begin
                if (over_range) begin
                    count_nxt = max_val;
                end else if (!at_zero) begin
                    count_nxt = count - WIDTH'(1);
                end else if (sat_mode) begin
                    sat_nxt   = 1'b1;
                end else begin
                    count_nxt = max_val;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= RESET_VALUE;
            wrap_evt <= 1'b0;
            sat_hit  <= 1'b0;
        end else begin
            count    <= count_nxt;
            wrap_evt <= wrap_nxt;
            sat_hit  <= sat_nxt;
        end
    end

`ifdef UDCNT_STICKY_OVF_EN
    // a new event outranks a concurrent clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky <= 1'b0;
        end else if (wrap_nxt || sat_nxt) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule
